// File: rtl/two_port_buffer_if.sv
// two_port_buffer_if: write/read port bundle between an initiator (master) and the buffer (slave).
interface two_port_buffer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  wr_csb;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_din;
    logic                  rd_csb;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_dout;
    logic                  rd_dout_vld;
    logic                  init_done;
    logic                  collision;
    modport master (
        output wr_csb, wr_addr, wr_din, rd_csb, rd_addr,
        input  rd_dout, rd_dout_vld, init_done, collision
    );
    modport slave (
        input  wr_csb, wr_addr, wr_din, rd_csb, rd_addr,
        output rd_dout, rd_dout_vld, init_done, collision
    );
endinterface

// File: rtl/two_port_buffer.sv
// two_port_buffer: two-port RAM with pipelined reads, collision flag and optional post-reset zero fill.
// Define TWO_PORT_BUFFER_WR_BYPASS_EN for write-first data on same-address collisions (read-first otherwise).
module two_port_buffer #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 256,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic              clk,
    input logic              rst,
    two_port_buffer_if.slave bus
);
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("two_port_buffer: RD_LATENCY must be 1..4");
    end
    if (DEPTH > 2 ** ADDR_WIDTH) begin : g_bad_depth
        $error("two_port_buffer: DEPTH exceeds address space");
    end
    typedef enum logic {INIT, READY} state_t;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] clr_cnt, mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd, arr_word, rd_word;
    logic                  mem_we, rd_req, hit;
    logic [RD_LATENCY-1:0] p_vld;
    logic [DATA_WIDTH-1:0] p_dat [RD_LATENCY];

    always_ff @(posedge clk)
        state <= rst ? (CLEAR_ON_RESET != 0 ? INIT : READY) : state_nxt;

    always_comb state_nxt = (state == INIT && clr_cnt == LAST) ? READY : state;

    always_comb begin
        bus.init_done = state == READY;
        rd_req        = !rst && state == READY && !bus.rd_csb;
        hit           = rd_req && !bus.wr_csb && bus.rd_addr == bus.wr_addr && {1'b0, bus.rd_addr} < DEPTH_W;
        mem_we        = !rst && (state == INIT || (!bus.wr_csb && {1'b0, bus.wr_addr} < DEPTH_W));
        mem_wa        = state == INIT ? clr_cnt : bus.wr_addr;
        mem_wd        = state == INIT ? '0 : bus.wr_din;
    end

    always_ff @(posedge clk)
        clr_cnt <= (rst || state != INIT) ? '0 : clr_cnt + 1'b1;

    always_ff @(posedge clk)
        if (mem_we) mem[mem_wa] <= mem_wd;

    // Array is sampled before this edge's write lands, so the default build is read-first.
    always_comb begin
        arr_word = {1'b0, bus.rd_addr} < DEPTH_W ? mem[bus.rd_addr] : '0;
`ifdef TWO_PORT_BUFFER_WR_BYPASS_EN
        rd_word  = hit ? bus.wr_din : arr_word;
`else
        rd_word  = arr_word;
`endif
    end

    // Each stage only loads on a valid beat, so the last stage holds rd_dout between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_vld         <= '0;
            for (int i = 0; i < RD_LATENCY; i++) p_dat[i] <= '0;
            bus.collision <= 1'b0;
        end else begin
            p_vld[0]      <= rd_req;
            if (rd_req) p_dat[0] <= rd_word;
            for (int i = 1; i < RD_LATENCY; i++) begin
                p_vld[i] <= p_vld[i-1];
                if (p_vld[i-1]) p_dat[i] <= p_dat[i-1];
            end
            bus.collision <= hit;
        end
    end

    assign bus.rd_dout_vld = p_vld[RD_LATENCY-1];
    assign bus.rd_dout     = p_dat[RD_LATENCY-1];
endmodule

// File: tb/tb_two_port_buffer.sv
// tb_two_port_buffer: four buffer configurations share one stimulus stream and are checked
// cycle by cycle against a queue-based model, plus directed checks of the key scenarios.
module tb_two_port_buffer;
    logic        clk = 0, rst = 1;
    logic        wr_csb = 1, rd_csb = 1;
    logic [7:0]  wr_addr = 0, rd_addr = 0;
    logic [31:0] wr_din = 0;
    logic        vld_o [4], col_o [4], init_o [4];
    logic [31:0] dout_o [4];
    int          n_chk = 0, n_fail = 0, e = 0;

    typedef struct { int due; logic [31:0] d; } rd_t;
    rd_t         q [4][$];
    logic [31:0] mem_m [4][256];
    logic [31:0] x_dout [4];
    logic        x_vld [4], x_col [4];
    int          busy [4], vld_e [4], vld_n [4], col_n [4];

`ifdef TWO_PORT_BUFFER_WR_BYPASS_EN
    localparam logic [31:0] COL_EXP = 32'h22222222;
`else
    localparam logic [31:0] COL_EXP = 32'h11111111;
`endif

    always #5 clk = ~clk;

    // Config k: RD_LATENCY=k+1; k=1 has DEPTH=200; k=3 keeps contents across reset.
    function automatic int dep_of(int k); return k == 1 ? 200 : 256; endfunction
    function automatic bit clr_of(int k); return k != 3; endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        two_port_buffer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
        assign bus.wr_csb  = wr_csb;
        assign bus.wr_addr = wr_addr;
        assign bus.wr_din  = wr_din;
        assign bus.rd_csb  = rd_csb;
        assign bus.rd_addr = rd_addr;
        assign vld_o[g]    = bus.rd_dout_vld;
        assign dout_o[g]   = bus.rd_dout;
        assign col_o[g]    = bus.collision;
        assign init_o[g]   = bus.init_done;
        two_port_buffer #(
            .ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(g == 1 ? 200 : 256),
            .RD_LATENCY(g + 1), .CLEAR_ON_RESET(g == 3 ? 0 : 1)
        ) dut (.clk(clk), .rst(rst), .bus(bus));
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [31:0] d;
        bit          hit;
        e++;
        for (int k = 0; k < 4; k++) begin
            x_col[k] = 0;
            if (rst) begin
                q[k].delete();
                x_vld[k]  = 0;
                x_dout[k] = 0;
                busy[k]   = e + (clr_of(k) ? dep_of(k) : 0);
                if (clr_of(k)) for (int a = 0; a < 256; a++) mem_m[k][a] = 0;
            end else begin
                if (e > busy[k] && !rd_csb) begin
                    hit = !wr_csb && wr_addr == rd_addr && rd_addr < dep_of(k);
                    d   = rd_addr < dep_of(k) ? mem_m[k][rd_addr] : 32'h0;
`ifdef TWO_PORT_BUFFER_WR_BYPASS_EN
                    if (hit) d = wr_din;
`endif
                    x_col[k] = hit;
                    q[k].push_back('{e + k, d});
                end
                if (e > busy[k] && !wr_csb && wr_addr < dep_of(k)) mem_m[k][wr_addr] = wr_din;
                x_vld[k] = q[k].size() > 0 && q[k][0].due == e;
                if (x_vld[k]) begin
                    x_dout[k] = q[k][0].d;
                    void'(q[k].pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("vld[%0d]@%0d", k, e), 32'(vld_o[k]), 32'(x_vld[k]));
            check($sformatf("col[%0d]@%0d", k, e), 32'(col_o[k]), 32'(x_col[k]));
            check($sformatf("init_done[%0d]@%0d", k, e), 32'(init_o[k]), 32'(e >= busy[k]));
            if (!$isunknown(x_dout[k])) check($sformatf("dout[%0d]@%0d", k, e), dout_o[k], x_dout[k]);
            if (vld_o[k]) begin vld_e[k] = e; vld_n[k]++; end
            if (col_o[k]) col_n[k]++;
        end
    endtask

    task automatic drive(bit w, bit r, logic [7:0] wa, logic [31:0] wd, logic [7:0] ra);
        wr_csb = !w; rd_csb = !r; wr_addr = wa; wr_din = wd; rd_addr = ra;
        step();
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 0, 0, 0);
    endtask

    // Reads are issued throughout INIT; the cycle budget bounds the wait.
    task automatic wait_init(output int cnt);
        int v0;
        v0  = vld_n[0];
        cnt = 0;
        while (!init_o[0] && cnt < 400) begin
            drive(0, 1, 0, 0, 8'($urandom));
            cnt++;
        end
        check("init_no_vld", vld_n[0] - v0, 0);
    endtask

    function automatic logic [7:0] pick();
        return $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(190, 255));
    endfunction

    initial begin
        int cnt, n0, v[4], c[4];
        for (int k = 0; k < 4; k++) begin
            busy[k] = 0; vld_n[k] = 0; col_n[k] = 0; vld_e[k] = 0;
            for (int a = 0; a < 256; a++) mem_m[k][a] = 'x;
        end
        rst = 1; step(); step(); rst = 0;
        wait_init(cnt);
        check("init_latency", cnt, 256);
        for (int a = 0; a < 256; a++) drive(1, 0, 8'(a), $urandom | 32'h1, 0);
        rst = 1; idle(1); rst = 0;
        wait_init(cnt);
        check("init_latency2", cnt, 256);
        foreach (v[i]) v[i] = 0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, i == 0 ? 8'h00 : i == 1 ? 8'h7F : 8'hFF);
            idle(5);
            check($sformatf("clear_rd%0d", i), dout_o[0], 0);
        end
        drive(1, 0, 8'h10, 32'hDEADBEEF, 0);
        foreach (v[k]) v[k] = vld_n[k];
        n0 = e + 1;
        drive(0, 1, 0, 0, 8'h10);
        idle(6);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("lat_edge[%0d]", k), vld_e[k] - n0, k);
            check($sformatf("lat_cnt[%0d]", k), vld_n[k] - v[k], 1);
            check($sformatf("lat_data[%0d]", k), dout_o[k], 32'hDEADBEEF);
        end
        for (int i = 0; i < 8; i++) drive(1, 0, 8'(i), 32'h100 + i, 0);
        foreach (v[k]) v[k] = vld_n[k];
        for (int i = 0; i < 8; i++) drive(0, 1, 0, 0, 8'(i));
        idle(6);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pipe_cnt[%0d]", k), vld_n[k] - v[k], 8);
            check($sformatf("pipe_last[%0d]", k), dout_o[k], 32'h107);
        end
        drive(1, 0, 8'h20, 32'h11111111, 0);
        foreach (c[k]) c[k] = col_n[k];
        drive(1, 1, 8'h20, 32'h22222222, 8'h20);
        idle(6);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("col_pulse[%0d]", k), col_n[k] - c[k], 1);
            check($sformatf("col_data[%0d]", k), dout_o[k], COL_EXP);
            c[k] = col_n[k];
        end
        drive(1, 1, 8'h21, 32'h33333333, 8'h20);
        idle(6);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("nocol_pulse[%0d]", k), col_n[k] - c[k], 0);
            check($sformatf("nocol_data[%0d]", k), dout_o[k], 32'h22222222);
        end
        drive(1, 0, 8'h70, 32'h5A5A, 0);
        drive(1, 0, 8'hF0, 32'hABCD, 0);
        v[1] = vld_n[1];
        drive(0, 1, 0, 0, 8'hF0);
        idle(3);
        check("oor_vld", vld_n[1] - v[1], 1);
        check("oor_data", dout_o[1], 0);
        check("inrange_data", dout_o[0], 32'hABCD);
        drive(0, 1, 0, 0, 8'h70);
        idle(3);
        check("oor_alias", dout_o[1], 32'h5A5A);
        drive(1, 0, 8'h33, 32'hC0FFEE, 0);
        v[2] = vld_n[2];
        drive(0, 1, 0, 0, 8'h33);
        rst = 1; idle(1); rst = 0;
        wait_init(cnt);
        check("rst_mid_vld", vld_n[2] - v[2], 0);
        check("rst_mid_init", cnt, 256);
        drive(0, 1, 0, 0, 8'h33);
        idle(6);
        check("retain_data", dout_o[3], 32'hC0FFEE);
        check("cleared_data", dout_o[0], 0);
        for (int i = 0; i < 3000; i++) begin
            rst     = $urandom_range(0, 1999) == 0;
            wr_csb  = $urandom_range(0, 2) == 0;
            rd_csb  = $urandom_range(0, 2) == 0;
            wr_addr = pick();
            rd_addr = $urandom_range(0, 3) == 0 ? wr_addr : pick();
            wr_din  = $urandom;
            step();
        end
        rst = 0;
        idle(6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
